soc_pipelined_mem: RTL

Unified instruction/data memory behind the CV32E40X SoC wrapper's merged `mem_*` port. It consumes the wrapper's request stream and produces the `mem_rvalid`/`mem_err`/`mem_rdata` responses that the wrapper's in-order source-tracking shift register routes back to the fetch and LSU paths. It is a grant-less, fully pipelined, fixed-latency synchronous RAM with byte-enable writes and an out-of-range error. It also provides a TOHOST mailbox that ends simulation.

---
 rtl/soc_pipelined_mem_pkg.sv | 15 +
 rtl/soc_pipelined_mem_if.sv | 26 ++
 rtl/soc_pipelined_mem_resp_pipe.sv | 33 +++
 rtl/soc_pipelined_mem.sv | 112 +++++++++++
 4 files changed

// File: rtl/soc_pipelined_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory.
// Response bundle, latency bound and mailbox default address.
package soc_mem_pkg;

    localparam int MEM_W = 32;
    localparam int MAX_LATENCY = 31;
    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'hFFFF_FFF0;

    typedef struct packed {
        logic             valid;
        logic             err;
        logic [MEM_W-1:0] rdata;
    } mem_resp_t;

endpackage

// File: rtl/soc_pipelined_mem_if.sv
// Merged mem_* request/response port between wrapper and memory.
// Grant-less: the memory accepts every request it sees.
interface soc_pipelined_mem_if #(
    parameter int MEM_W = 32
);
    logic               mem_req_i;
    logic [31:0]        mem_addr_i;
    logic               mem_we_i;
    logic [MEM_W/8-1:0] mem_be_i;
    logic [MEM_W-1:0]   mem_wdata_i;
    logic               mem_rvalid_o;
    logic               mem_err_o;
    logic [MEM_W-1:0]   mem_rdata_o;

    modport master (
        output mem_req_i, mem_addr_i, mem_we_i,
        output mem_be_i, mem_wdata_i,
        input  mem_rvalid_o, mem_err_o, mem_rdata_o
    );

    modport slave (
        input  mem_req_i, mem_addr_i, mem_we_i,
        input  mem_be_i, mem_wdata_i,
        output mem_rvalid_o, mem_err_o, mem_rdata_o
    );
endinterface

// File: rtl/soc_pipelined_mem_resp_pipe.sv
// Fixed-depth delay line carrying {valid, err, rdata} responses.
// Stage 0 is loaded on the accepting edge; the last stage drives out.
module soc_mem_resp_pipe
    import soc_mem_pkg::*;
#(
    parameter int  LATENCY = 1,
    parameter type resp_t  = mem_resp_t
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  resp_t d_i,
    output resp_t q_o
);

    resp_t stage_q [LATENCY];

    // Shift every stage each cycle; reset drops all in-flight responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[LATENCY-1];

endmodule

// File: rtl/soc_pipelined_mem.sv
// Unified I/D RAM with byte-enable writes, range error and TOHOST mailbox.
// Fully pipelined, fixed latency, one response per request in order.
module soc_pipelined_mem
    import soc_mem_pkg::*;
#(
    parameter int          MEM_W       = 32,
    parameter int          MEM_SIZE    = 65536,
    parameter int          LATENCY     = 1,
    parameter string       INIT_FILE   = "",
    parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    soc_pipelined_mem_if.slave   mem,
    output logic                 done_o,
    output logic [31:0]          exit_code_o
);

    localparam int NBYTES = MEM_W / 8;
    localparam int AW     = $clog2(MEM_SIZE);
    localparam int BW     = $clog2(NBYTES);
    localparam int DEPTH  = MEM_SIZE / NBYTES;
    localparam logic [31:0] BMASK = 32'(NBYTES - 1);

    typedef struct packed {
        logic             valid;
        logic             err;
        logic [MEM_W-1:0] rdata;
    } resp_t;

    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("soc_pipelined_mem: LATENCY must be 1..%0d", MAX_LATENCY);
    end

    logic [MEM_W-1:0] mem_q [DEPTH];

    logic [AW-BW-1:0] idx;
    logic             in_range;
    logic             hit_tohost;
    logic             mem_wr;
    logic             tohost_wr;
    resp_t            resp_d;
    resp_t            resp_q;
    logic             done_q, done_d;
    logic [31:0]      exit_q, exit_d;

    assign idx        = mem.mem_addr_i[AW-1:BW];
    assign in_range   = {32'd0, mem.mem_addr_i} < 64'(MEM_SIZE);
    assign hit_tohost = (mem.mem_addr_i & ~BMASK) == (TOHOST_ADDR & ~BMASK);
    assign mem_wr     = mem.mem_req_i & mem.mem_we_i & in_range;
    assign tohost_wr  = mem.mem_req_i & mem.mem_we_i & hit_tohost
                      & (mem.mem_be_i[3:0] == 4'hF);

    // Byte-enabled array write; contents deliberately survive reset.
    always @(posedge clk_i) begin
        if (mem_wr) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (mem.mem_be_i[b]) begin
                    mem_q[idx][8*b +: 8] <= mem.mem_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Build the response for the request accepted this cycle.
    always_comb begin
        resp_d       = '0;
        resp_d.valid = mem.mem_req_i;
        resp_d.err   = mem.mem_req_i & ~in_range & ~hit_tohost;
        if (mem.mem_req_i && !mem.mem_we_i) begin
            if (in_range) begin
                resp_d.rdata = mem_q[idx];
            end else if (hit_tohost) begin
                resp_d.rdata = MEM_W'(exit_q);
            end
        end
    end

    // Mailbox next state: done is sticky, exit code takes the latest write.
    always_comb begin
        done_d = done_q | tohost_wr;
        exit_d = tohost_wr ? mem.mem_wdata_i[31:0] : exit_q;
    end

    // Mailbox registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q <= 1'b0;
            exit_q <= '0;
        end else begin
            done_q <= done_d;
            exit_q <= exit_d;
        end
    end

    soc_mem_resp_pipe #(
        .LATENCY (LATENCY),
        .resp_t  (resp_t)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (resp_d),
        .q_o    (resp_q)
    );

    assign mem.mem_rvalid_o = resp_q.valid;
    assign mem.mem_err_o    = resp_q.err;
    assign mem.mem_rdata_o  = resp_q.rdata;
    assign done_o           = done_q;
    assign exit_code_o      = exit_q;

endmodule
